// File: rtl/neuron_learn_target_seq_if.sv
// Handshake and data bundle between the training sequencer and its driver/learning layer.
// Layer elements are DW-bit unsigned fractions: 0 is 0.0, all-ones is 1.0.
interface neuron_learn_target_seq_if #(
  parameter int M     = 52,
  parameter int LBL_W = 6,
  parameter int DW    = 8,
  parameter int CNT_W = 16
);
  logic                  start;
  logic [LBL_W-1:0]      label;
  logic                  learn_en;
  logic [M-1:0][DW-1:0]  layer_out;
  logic                  valid;
  logic                  learn;
  logic [M-1:0][DW-1:0]  expected_out;
  logic                  busy;
  logic                  done;
  logic [LBL_W-1:0]      predicted;
  logic                  correct;
  logic                  label_err;
  logic [CNT_W-1:0]      hit_count;
  logic [CNT_W-1:0]      sample_count;

  modport master (
    output start, label, learn_en, layer_out,
    input  valid, learn, expected_out, busy, done, predicted, correct, label_err,
           hit_count, sample_count
  );

  modport slave (
    input  start, label, learn_en, layer_out,
    output valid, learn, expected_out, busy, done, predicted, correct, label_err,
           hit_count, sample_count
  );
endinterface

// File: rtl/neuron_learn_target_seq.sv
// Training sequencer: evaluates a sample on the learning layer, finds the argmax serially,
// then drives a one-hot target and a learn pulse for the labelled class.
//
// state | meaning
// IDLE  | waiting for start; label/learn_en latched on accept
// EVAL  | valid pulse to the layer
// WAIT  | LAT-cycle settle down-counter
// SCAN  | one layer element per cycle, running argmax
// LEARN | one-hot target driven, valid+learn pulse
// FIN   | done pulse, counters update
module neuron_learn_target_seq #(
  parameter int M     = 52,
  parameter int LBL_W = 6,
  parameter int LAT   = 1,
  parameter int CNT_W = 16,
  parameter int DW    = 8
) (
  input logic                     clock,
  input logic                     reset_n,
  neuron_learn_target_seq_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_EVAL, S_WAIT, S_SCAN, S_LEARN, S_FIN
  } state_t;

  state_t               r_state, w_next;
  logic [LBL_W-1:0]     r_label, r_idx, r_best, r_predicted;
  logic                 r_learn_en, r_correct, r_label_err;
  logic [3:0]           r_wait_cnt;
  logic [DW-1:0]        r_best_val;
  logic [CNT_W-1:0]     r_hit, r_samp;
  logic [M-1:0][DW-1:0] r_expected, w_target;
  logic [DW-1:0]        w_cur;
  logic [LBL_W-1:0]     w_best_nxt;
  logic                 w_take, w_last, w_label_ok, w_do_learn;

  // Strict compare keeps the lowest index on ties; element 0 always seeds the search.
  assign w_cur      = bus.layer_out[r_idx];
  assign w_take     = (r_idx == '0) || (w_cur > r_best_val);
  assign w_best_nxt = w_take ? r_idx : r_best;
  assign w_last     = (r_idx == LBL_W'(M - 1));
  assign w_label_ok = ({1'b0, r_label} < (LBL_W + 1)'(M));
  assign w_do_learn = r_learn_en && w_label_ok;

  always_comb begin
    w_target = '0;
    for (int i = 0; i < M; i++) begin
      if (r_label == LBL_W'(i)) w_target[i] = '1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = S_EVAL;
      S_EVAL:  w_next = S_WAIT;
      S_WAIT:  if (r_wait_cnt == '0) w_next = S_SCAN;
      S_SCAN:  if (w_last) w_next = w_do_learn ? S_LEARN : S_FIN;
      S_LEARN: w_next = S_FIN;
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_label     <= '0;
      r_learn_en  <= 1'b0;
      r_wait_cnt  <= '0;
      r_idx       <= '0;
      r_best      <= '0;
      r_best_val  <= '0;
      r_predicted <= '0;
      r_correct   <= 1'b0;
      r_label_err <= 1'b0;
      r_hit       <= '0;
      r_samp      <= '0;
      r_expected  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_label    <= bus.label;
            r_learn_en <= bus.learn_en;
            r_wait_cnt <= '0;
          end
        end
        S_EVAL: r_wait_cnt <= 4'(LAT - 1);
        S_WAIT: begin
          if (r_wait_cnt != '0) begin
            r_wait_cnt <= r_wait_cnt - 4'd1;
          end else begin
            r_idx      <= '0;
            r_best     <= '0;
            r_best_val <= '0;
          end
        end
        S_SCAN: begin
          r_best <= w_best_nxt;
          if (w_take) r_best_val <= w_cur;
          r_idx <= r_idx + 1'b1;
          if (w_last) begin
            r_predicted <= w_best_nxt;
            r_correct   <= (w_best_nxt == r_label);
            r_label_err <= !w_label_ok;
            // Target is registered on entry to LEARN so it is already valid during the pulse.
            if (w_do_learn) r_expected <= w_target;
          end
        end
        S_FIN: begin
          if (r_samp != '1) r_samp <= r_samp + 1'b1;
          if (r_correct && !r_label_err && (r_hit != '1)) r_hit <= r_hit + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.valid        = (r_state == S_EVAL) || (r_state == S_LEARN);
  assign bus.learn        = (r_state == S_LEARN);
  assign bus.busy         = (r_state != S_IDLE) && (r_state != S_FIN);
  assign bus.done         = (r_state == S_FIN);
  assign bus.expected_out = r_expected;
  assign bus.predicted    = r_predicted;
  assign bus.correct      = r_correct;
  assign bus.label_err    = r_label_err;
  assign bus.hit_count    = r_hit;
  assign bus.sample_count = r_samp;

endmodule

// File: tb/tb_neuron_learn_target_seq.sv
// Directed, table-driven bench for the training sequencer (M=52 instance plus a small
// M=4/LAT=3/CNT_W=4 instance for latency and counter saturation).
module tb_neuron_learn_target_seq;
  localparam int M  = 52, LW  = 6, LAT  = 1, CW  = 16, DW = 8;
  localparam int M2 = 4,  LW2 = 2, LAT2 = 3, CW2 = 4;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  neuron_learn_target_seq_if #(.M(M),  .LBL_W(LW),  .DW(DW), .CNT_W(CW))  bus0();
  neuron_learn_target_seq_if #(.M(M2), .LBL_W(LW2), .DW(DW), .CNT_W(CW2)) bus1();

  neuron_learn_target_seq #(.M(M), .LBL_W(LW), .LAT(LAT), .CNT_W(CW), .DW(DW)) u_dut0 (
    .clock(clock), .reset_n(reset_n), .bus(bus0.slave));
  neuron_learn_target_seq #(.M(M2), .LBL_W(LW2), .LAT(LAT2), .CNT_W(CW2), .DW(DW)) u_dut1 (
    .clock(clock), .reset_n(reset_n), .bus(bus1.slave));

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int          hi;
    int          tie;
    logic [7:0]  hi_val;
    logic [5:0]  label;
    logic        len;
    logic [5:0]  pred;
    logic        corr;
    logic        lerr;
    logic        lrn;
    int          done_c;
  } vec_t;

  vec_t vecs[6];

  int                   m_hit, m_samp;
  logic [M-1:0][DW-1:0] m_exp;

  task automatic set_layer(input int hi, input int tie, input logic [7:0] v);
    for (int i = 0; i < M; i++) bus0.layer_out[i] = DW'((i * 7) % 128);
    if (hi >= 0)  bus0.layer_out[hi]  = v;
    if (tie >= 0) bus0.layer_out[tie] = v;
  endtask

  task automatic run_seq(input logic [5:0] lbl, input logic len,
                         output int nvalid, output int v_first, output int nlearn,
                         output int learn_c, output int done_c, output logic busy1);
    nvalid = 0; v_first = -1; nlearn = 0; learn_c = -1; done_c = -1; busy1 = 1'b0;
    @(negedge clock);
    bus0.start = 1'b1; bus0.label = lbl; bus0.learn_en = len;
    for (int c = 1; c <= 90 && done_c < 0; c++) begin
      @(negedge clock);
      if (c == 1) begin
        bus0.start = 1'b0;
        busy1 = bus0.busy;
      end
      if (bus0.valid) begin
        nvalid++;
        if (v_first < 0) v_first = c;
      end
      if (bus0.learn) begin
        nlearn++;
        learn_c = c;
      end
      if (bus0.done) done_c = c;
    end
  endtask

  initial begin
    int nv, vf, nl, lc, dc;
    logic b1;
    logic bad;
    int vq[$];
    int dq[$];

    vecs[0] = '{17, -1, 8'hC0, 6'd17, 1'b1, 6'd17, 1'b1, 1'b0, 1'b1, 56};
    vecs[1] = '{5,  40, 8'hC0, 6'd40, 1'b1, 6'd5,  1'b0, 1'b0, 1'b1, 56};
    vecs[2] = '{20, -1, 8'hC0, 6'd60, 1'b1, 6'd20, 1'b0, 1'b1, 1'b0, 55};
    vecs[3] = '{3,  -1, 8'hC0, 6'd3,  1'b0, 6'd3,  1'b1, 1'b0, 1'b0, 55};
    vecs[4] = '{51, -1, 8'hC0, 6'd51, 1'b1, 6'd51, 1'b1, 1'b0, 1'b1, 56};
    vecs[5] = '{0,  -1, 8'hFF, 6'd2,  1'b1, 6'd0,  1'b0, 1'b0, 1'b1, 56};

    bus1.start = 1'b0; bus1.label = '0; bus1.learn_en = 1'b0;
    for (int i = 0; i < M2; i++) bus1.layer_out[i] = (i == 2) ? 8'hC0 : 8'h10;

    // Reset held with start asserted: everything stays at zero.
    set_layer(17, -1, 8'hC0);
    bus0.start = 1'b1; bus0.label = 6'd17; bus0.learn_en = 1'b1;
    bad = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      if ({bus0.valid, bus0.learn, bus0.busy, bus0.done, bus0.correct, bus0.label_err,
           bus0.predicted, bus0.hit_count, bus0.sample_count} != '0) bad = 1'b1;
      if (bus0.expected_out != '0) bad = 1'b1;
    end
    chk("reset_outputs_nonzero", bad, 1'b0);
    bus0.start = 1'b0;
    reset_n = 1'b1;
    bad = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      if (bus0.valid || bus0.busy) bad = 1'b1;
    end
    chk("valid_without_start", bad, 1'b0);

    m_hit = 0; m_samp = 0; m_exp = '0;

    foreach (vecs[k]) begin
      set_layer(vecs[k].hi, vecs[k].tie, vecs[k].hi_val);
      run_seq(vecs[k].label, vecs[k].len, nv, vf, nl, lc, dc, b1);
      chk($sformatf("v%0d_busy_c1", k), b1, 1'b1);
      chk($sformatf("v%0d_valid_first", k), vf, 1);
      chk($sformatf("v%0d_valid_n", k), nv, vecs[k].lrn ? 2 : 1);
      chk($sformatf("v%0d_learn_n", k), nl, vecs[k].lrn ? 1 : 0);
      chk($sformatf("v%0d_learn_cyc", k), lc, vecs[k].lrn ? 55 : -1);
      chk($sformatf("v%0d_done_cyc", k), dc, vecs[k].done_c);
      chk($sformatf("v%0d_busy_done", k), bus0.busy, 1'b0);
      chk($sformatf("v%0d_pred", k), bus0.predicted, vecs[k].pred);
      chk($sformatf("v%0d_correct", k), bus0.correct, vecs[k].corr);
      chk($sformatf("v%0d_label_err", k), bus0.label_err, vecs[k].lerr);
      m_samp++;
      if (vecs[k].corr && !vecs[k].lerr) m_hit++;
      if (vecs[k].lrn) begin
        m_exp = '0;
        m_exp[vecs[k].label] = '1;
      end
      @(negedge clock);
      chk($sformatf("v%0d_hit", k), bus0.hit_count, m_hit);
      chk($sformatf("v%0d_samples", k), bus0.sample_count, m_samp);
      chk($sformatf("v%0d_expected_out", k), bus0.expected_out, m_exp);
    end

    // Busy guard: starts at 10 (busy) and 56 (FIN) dropped, start at 58 accepted.
    set_layer(17, -1, 8'hC0);
    @(negedge clock);
    bus0.start = 1'b1; bus0.label = 6'd17; bus0.learn_en = 1'b1;
    for (int c = 1; c <= 130 && dq.size() < 2; c++) begin
      @(negedge clock);
      bus0.start    = (c == 10) || (c == 56) || (c == 58);
      bus0.label    = (c == 10) ? 6'd9 : 6'd17;
      bus0.learn_en = (c == 10) ? 1'b0 : 1'b1;
      if (bus0.valid) vq.push_back(c);
      if (bus0.done)  dq.push_back(c);
    end
    bus0.start = 1'b0;
    chk("guard_valid_n", vq.size(), 4);
    chk("guard_valid0", vq[0], 1);
    chk("guard_valid1", vq[1], 55);
    chk("guard_valid2", vq[2], 59);
    chk("guard_done0", dq[0], 56);
    chk("guard_done1", dq[1], 114);
    chk("guard_pred", bus0.predicted, 6'd17);
    m_samp += 2; m_hit += 2;
    m_exp = '0; m_exp[17] = '1;
    @(negedge clock);
    chk("guard_samples", bus0.sample_count, m_samp);
    chk("guard_hit", bus0.hit_count, m_hit);

    // Abort mid-scan with reset: no learn pulse may follow.
    set_layer(30, -1, 8'hC0);
    @(negedge clock);
    bus0.start = 1'b1; bus0.label = 6'd30; bus0.learn_en = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clock);
      bus0.start = 1'b0;
    end
    reset_n = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("abort_counters", {bus0.hit_count, bus0.sample_count}, '0);
    chk("abort_busy", bus0.busy, 1'b0);
    chk("abort_expected_out", bus0.expected_out, '0);
    reset_n = 1'b1;
    nl = 0; nv = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clock);
      if (bus0.learn) nl++;
      if (bus0.valid) nv++;
    end
    chk("abort_learn_after", nl, 0);
    chk("abort_valid_after", nv, 0);

    // Small instance: LAT=3 latency, then counter saturation at 4 bits.
    dc = -1; lc = -1;
    for (int s = 0; s < 18; s++) begin
      logic seen;
      seen = 1'b0;
      @(negedge clock);
      bus1.start = 1'b1; bus1.label = 2'd2; bus1.learn_en = 1'b1;
      for (int c = 1; c <= 30 && !seen; c++) begin
        @(negedge clock);
        bus1.start = 1'b0;
        if (s == 0 && bus1.learn) lc = c;
        if (bus1.done) begin
          seen = 1'b1;
          if (s == 0) dc = c;
        end
      end
      if (!seen) chk($sformatf("small_done_timeout_s%0d", s), seen, 1'b1);
    end
    chk("small_learn_cyc", lc, 2 + LAT2 + M2);
    chk("small_done_cyc", dc, 3 + LAT2 + M2);
    @(negedge clock);
    chk("sat_hit", bus1.hit_count, 4'hF);
    chk("sat_samples", bus1.sample_count, 4'hF);
    chk("small_pred", bus1.predicted, 2'd2);
    chk("small_expected_out", bus1.expected_out, 32'h00FF_0000);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
